// File: rtl/fp16_acc_pkg.sv
// Shared constants for the fp16 accumulator job scheduler: FP16 width,
// the zero encoding and the scheduler FSM state codes.
package fp16_acc_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Scheduler FSM states
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FILL    = 3'd1;
  localparam logic [2:0] BURST   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

endpackage

// File: rtl/fp16_acc_sched_rr_arb.sv
// N_REQ-wide round-robin arbiter. The search starts at the pointer, and the
// pointer moves to one past the winner only when a grant is actually issued.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] sel;
  logic            found;
  int              idx;

  // Scan requesters starting at the pointer; the first active one wins
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_W'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        id_o       = sel;
      end
    end
  end

  // Next priority pointer: one past the winner, wrapping to requester 0
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (id_o == ID_W'(N_REQ - 1)) ? '0 : id_o + ID_W'(1);
    end
  end

  // Pointer register; requester 0 has top priority out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp16_acc_sched.sv
// Job scheduler in front of a shared single-stream FP16 accumulator.
// A granted requester's job is buffered whole, then replayed as one gap-free
// burst with the done strobe on the last beat; the sum is returned with the
// owner's ID and a truncation flag.
module fp16_acc_sched
  import fp16_acc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = 16,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [FP16_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FP16_W-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_trunc,
  output logic [FP16_W-1:0]       acc_in_a,
  output logic                    acc_in_accum_done,
  input  logic [FP16_W-1:0]       acc_out_sum,
  output logic                    busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              trunc_q, trunc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FP16_W-1:0] mem_q [DEPTH];
  logic              push;

  logic [FP16_W-1:0] acc_a_q, acc_a_d;
  logic              acc_done_q, acc_done_d;
  logic              res_valid_q, res_valid_d;
  logic [FP16_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_trunc_q, res_trunc_d;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_id;

  logic [FP16_W-1:0] beat_data;
  logic              beat_vld;
  logic              beat_last;
  logic              fill_end;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .id_o  (arb_id)
  );

  assign beat_data = req_data[FP16_W*int'(id_q) +: FP16_W];
  assign beat_vld  = (state_q == FILL) && req_valid[id_q];
  assign beat_last = req_last[id_q];
  // The DEPTH-th beat closes the job even without last, so the FIFO never overflows
  assign fill_end  = beat_vld && (beat_last || (cnt_q == CNT_W'(DEPTH - 1)));

  assign req_ready         = (state_q == FILL) ? (N_REQ'(1) << id_q) : '0;
  assign busy              = (state_q != IDLE);
  assign acc_in_a          = acc_a_q;
  assign acc_in_accum_done = acc_done_q;
  assign res_valid         = res_valid_q;
  assign res_data          = res_data_q;
  assign res_id            = res_id_q;
  assign res_trunc         = res_trunc_q;

  // FSM, FIFO pointers and registered accumulator/result drive
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    trunc_d     = trunc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push        = 1'b0;
    arb_en      = 1'b0;
    acc_a_d     = FP16_ZERO;
    acc_done_d  = 1'b1;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_trunc_d = res_trunc_q;

    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (|req_valid) begin
          id_d    = arb_id;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (beat_vld) begin
          push     = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          cnt_d    = cnt_q + CNT_W'(1);
          if (fill_end) begin
            // Preload the first burst beat so the accumulator sees it in the
            // first BURST cycle; a single-beat job bypasses the FIFO read.
            state_d    = BURST;
            trunc_d    = ~beat_last;
            rem_d      = cnt_q + CNT_W'(1);
            acc_a_d    = (cnt_q == '0) ? beat_data : mem_q[rd_ptr_q];
            acc_done_d = (cnt_q == '0);
            rd_ptr_d   = ptr_inc(rd_ptr_q);
          end
        end
      end

      BURST: begin
        if (rem_q > CNT_W'(1)) begin
          acc_a_d    = mem_q[rd_ptr_q];
          acc_done_d = (rem_q == CNT_W'(2));
          rd_ptr_d   = ptr_inc(rd_ptr_q);
          rem_d      = rem_q - CNT_W'(1);
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        res_data_d  = acc_out_sum;
        res_id_d    = id_q;
        res_trunc_d = trunc_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end

      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control, pointers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      trunc_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_a_q     <= FP16_ZERO;
      acc_done_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= FP16_ZERO;
      res_id_q    <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      trunc_q     <= trunc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_a_q     <= acc_a_d;
      acc_done_q  <= acc_done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  // Job FIFO storage; contents are only meaningful between matching pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= beat_data;
  end

endmodule

// File: tb/tb_fp16_acc_sched.sv
// Bench for fp16_acc_sched with a behavioural FP16 accumulator attached.
module tb_fp16_acc_sched;

  localparam int N_REQ = 4;
  localparam int DEPTH = 4;
  localparam int ID_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_last;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [ID_W-1:0]   res_id;
  logic              res_trunc;
  logic [15:0]       acc_in_a;
  logic              acc_in_accum_done;
  logic [15:0]       acc_out_sum;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;
  int n_d0  = 0;
  int n_anz = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  id;
    logic        tr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp16_acc_sched #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_data          (req_data),
    .req_last          (req_last),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .res_id            (res_id),
    .res_trunc         (res_trunc),
    .acc_in_a          (acc_in_a),
    .acc_in_accum_done (acc_in_accum_done),
    .acc_out_sum       (acc_out_sum),
    .busy              (busy)
  );

  function automatic real fp16_to_real(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    m = (e == 0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
    if (e == 0) e = 1;
    for (int i = 0; i < e - 15; i++) m = m * 2.0;
    for (int i = 0; i < 15 - e; i++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    real  m;
    int   e;
    int   f;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
    if (m < 1.0) begin
      f = $rtoi(m * 1024.0 + 0.5);
      return {s, 5'd0, f[9:0]};
    end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (f == 1024) begin f = 0; e++; end
    return {s, e[4:0], f[9:0]};
  endfunction

  // Behavioural accumulator: sums while done=0, publishes the sum one cycle after done=1
  real acc_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r = 0.0;
      acc_out_sum <= 16'h0000;
    end else if (acc_in_accum_done) begin
      acc_out_sum <= real_to_fp16(acc_r + fp16_to_real(acc_in_a));
      acc_r = 0.0;
    end else begin
      acc_r = acc_r + fp16_to_real(acc_in_a);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [1:0] id, input logic tr);
    exp_t e;
    e.d = d; e.id = id; e.tr = tr;
    sb.push_back(e);
  endtask

  // Scoreboard: compare each accepted result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      chk("sb_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e.d));
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_trunc", 32'(res_trunc), 32'(e.tr));
      end
    end
  end

  // Accumulator stream observation: count non-done cycles and non-zero beats
  always @(negedge clk) begin
    if (!rst) begin
      if (!acc_in_accum_done) n_d0++;
      if (acc_in_a != 16'h0000) n_anz++;
    end
  end

  task automatic drive_job(input int r, input logic [79:0] beats, input int n, input bit lastf);
    int t;
    for (int i = 0; i < n; i++) begin
      req_valid[r] = 1'b1;
      req_data[16*r +: 16] = beats[16*i +: 16];
      req_last[r] = lastf && (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!req_ready[r] && t < 300) begin @(negedge clk); t++; end
      if (!req_ready[r]) begin
        chk("beat_accept", 32'(req_ready[r]), 32'd1);
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 500) begin @(negedge clk); t++; end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_res_data"}, 32'(res_data), 32'd0);
    chk({pfx, "_res_id"}, 32'(res_id), 32'd0);
    chk({pfx, "_res_trunc"}, 32'(res_trunc), 32'd0);
    chk({pfx, "_acc_a"}, 32'(acc_in_a), 32'd0);
    chk({pfx, "_acc_done"}, 32'(acc_in_accum_done), 32'd1);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; res_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1 rst = 1'b0;

    // req0: 1+2+3 = 6.0, latency 1+3+3+1 cycles to res_valid
    n_d0 = 0; n_anz = 0;
    push_exp(16'h4600, 2'd0, 1'b0);
    fork
      drive_job(0, {16'h0, 16'h0, 16'h4200, 16'h4000, 16'h3C00}, 3, 1'b1);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!res_valid && t < 100);
        chk("latency", 32'(t), 32'd9);
      end
    join
    drain("drain_t1");
    chk("t1_done_low", 32'(n_d0), 32'd2);
    chk("t1_beats", 32'(n_anz), 32'd3);

    // req2 single beat: done on its only beat
    n_d0 = 0; n_anz = 0;
    push_exp(16'h3C00, 2'd2, 1'b0);
    drive_job(2, {64'h0, 16'h3C00}, 1, 1'b1);
    drain("drain_t2");
    chk("t2_done_low", 32'(n_d0), 32'd0);
    chk("t2_beats", 32'(n_anz), 32'd1);

    // Fresh reset, then req0 and req1 collide twice
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_exp(16'h4000, 2'd0, 1'b0);
    push_exp(16'h4200, 2'd1, 1'b0);
    fork
      drive_job(0, {64'h0, 16'h4000}, 1, 1'b1);
      drive_job(1, {64'h0, 16'h4200}, 1, 1'b1);
    join
    drain("drain_t3a");
    push_exp(16'h4400, 2'd0, 1'b0);
    push_exp(16'h4500, 2'd1, 1'b0);
    fork
      drive_job(0, {64'h0, 16'h4400}, 1, 1'b1);
      drive_job(1, {64'h0, 16'h4500}, 1, 1'b1);
    join
    drain("drain_t3b");

    // req1 overlong job: first DEPTH beats truncate, fifth beat is its own job
    push_exp(16'h4B80, 2'd1, 1'b1);
    push_exp(16'h4C00, 2'd1, 1'b0);
    drive_job(1, {16'h4C00, 16'h4800, 16'h4400, 16'h4000, 16'h3C00}, 5, 1'b1);
    drain("drain_t4");

    // Result back-pressure: outputs hold, nothing else is accepted
    res_ready = 1'b0;
    push_exp(16'h4400, 2'd3, 1'b0);
    push_exp(16'h3C00, 2'd0, 1'b0);
    drive_job(3, {48'h0, 16'h4000, 16'h4000}, 2, 1'b1);
    t = 0;
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    chk("hold_rv_seen", 32'(res_valid), 32'd1);
    fork
      drive_job(0, {64'h0, 16'h3C00}, 1, 1'b1);
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_data", 32'(res_data), 32'h4400);
      chk("hold_res_id", 32'(res_id), 32'd3);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    drain("drain_t5");

    // Reset in the middle of a burst drops the job; resubmission is clean
    push_exp(16'h4600, 2'd0, 1'b0);
    drive_job(0, {16'h0, 16'h0, 16'h4200, 16'h4000, 16'h3C00}, 3, 1'b1);
    t = 0;
    while (acc_in_a == 16'h0000 && t < 50) begin @(negedge clk); t++; end
    chk("mid_burst_seen", 32'(acc_in_a != 16'h0000), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    push_exp(16'h4600, 2'd0, 1'b0);
    drive_job(0, {16'h0, 16'h0, 16'h4200, 16'h4000, 16'h3C00}, 3, 1'b1);
    drain("drain_t6");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
